sd_spi_read: RTL and testbench

Single-block read engine for the SD-card SPI path, driven from sd_spi_controller once sd_init_done is high. On a start request it issues CMD17 for one 512-byte sector, checks R1, and waits for the start token. It then streams the sector as 256 big-endian 16-bit words through rd_en/rd_data. Its CS/MOSI outputs feed the controller's read-branch signal mux, which routes them onto the pins while rd_busy is high.

---
 rtl/sd_spi_pkg.sv | 24 ++
 rtl/sd_spi_read_if.sv | 22 ++
 rtl/sd_spi_shift_rx.sv | 31 +++
 rtl/sd_spi_read.sv | 135 +++++++++++++
 tb/tb_sd_spi_read.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/sd_spi_pkg.sv
// Shared constants and state encoding for the SD-card SPI read path.
package sd_spi_pkg;

  localparam logic [7:0] CMD17_INDEX   = 8'h51;
  localparam logic [7:0] CMD_CRC_DUMMY = 8'hFF;
  localparam logic [7:0] START_TOKEN   = 8'hFE;
  localparam int         SECTOR_WORDS  = 256;
  localparam int         CMD_BITS      = 48;
  localparam int         DATA_BITS     = SECTOR_WORDS * 16;
  localparam int         CRC_BITS      = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEND_CMD,
    ST_WAIT_R1,
    ST_RECV_R1,
    ST_WAIT_TOKEN,
    ST_RECV_DATA,
    ST_RECV_CRC,
    ST_TAIL,
    ST_ERR
  } rd_state_t;

endpackage

// File: rtl/sd_spi_read_if.sv
// Request, card-pin and data-stream signals of the single-block read engine.
interface sd_spi_read_if;
  logic        sd_spi_miso;
  logic        rd_sd_cs;
  logic        rd_sd_mosi;
  logic        rd_start_en;
  logic [31:0] rd_sec_addr;
  logic        rd_busy;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_err;

  modport master (
    output sd_spi_miso, rd_start_en, rd_sec_addr,
    input  rd_sd_cs, rd_sd_mosi, rd_busy, rd_en, rd_data, rd_err
  );

  modport slave (
    input  sd_spi_miso, rd_start_en, rd_sec_addr,
    output rd_sd_cs, rd_sd_mosi, rd_busy, rd_en, rd_data, rd_err
  );
endinterface

// File: rtl/sd_spi_shift_rx.sv
// MSB-first 16-bit receive shifter; word/word_done show the value including the bit being shifted now.
module sd_spi_shift_rx (
  input  logic        clk_sd,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic        din,
  output logic [15:0] word,
  output logic        word_done
);

  logic [15:0] shift_reg;
  logic [3:0]  count_reg;

  always_ff @(posedge clk_sd or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      count_reg <= '0;
    end else if (clear) begin
      shift_reg <= '0;
      count_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= word;
      count_reg <= count_reg + 4'd1;
    end
  end

  assign word      = {shift_reg[14:0], din};
  assign word_done = shift_en & ~clear & (count_reg == 4'd15);

endmodule

// File: rtl/sd_spi_read.sv
// CMD17 single-sector read: sends the command, checks R1, waits for the start
// token and streams 256 big-endian words, then releases CS for the tail clocks.
module sd_spi_read
  import sd_spi_pkg::*;
#(
  parameter int RESP_TIMEOUT  = 255,
  parameter int TOKEN_TIMEOUT = 250000,
  parameter int TAIL_CLKS     = 8
) (
  input  logic         clk_sd,
  input  logic         reset_n,
  sd_spi_read_if.slave bus
);

  localparam logic [17:0] RESP_LIMIT  = 18'(RESP_TIMEOUT - 1);
  localparam logic [17:0] TOKEN_LIMIT = 18'(TOKEN_TIMEOUT - 1);
  localparam logic [12:0] CMD_LAST    = 13'(CMD_BITS - 1);
  localparam logic [12:0] DATA_LAST   = 13'(DATA_BITS - 1);
  localparam logic [12:0] CRC_LAST    = 13'(CRC_BITS - 1);
  localparam logic [12:0] TAIL_LAST   = 13'(TAIL_CLKS - 1);

  rd_state_t   state_reg, state_next;
  logic [12:0] bit_cnt_reg, bit_cnt_next;
  logic [17:0] tmo_reg, tmo_next;
  logic [47:0] cmd_reg, cmd_next;
  logic        rd_en_reg, rd_en_next;
  logic [15:0] rd_data_reg, rd_data_next;
  logic        start_prev_reg;
  logic        start;
  logic        rx_clear, rx_shift, rx_done;
  logic [15:0] rx_word;

  assign start = bus.rd_start_en & ~start_prev_reg;

  sd_spi_shift_rx u_rx (
    .clk_sd    (clk_sd),
    .reset_n   (reset_n),
    .clear     (rx_clear),
    .shift_en  (rx_shift),
    .din       (bus.sd_spi_miso),
    .word      (rx_word),
    .word_done (rx_done)
  );

  always_ff @(posedge clk_sd or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= '0;
      tmo_reg        <= '0;
      cmd_reg        <= '1;
      rd_en_reg      <= 1'b0;
      rd_data_reg    <= '0;
      start_prev_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      tmo_reg        <= tmo_next;
      cmd_reg        <= cmd_next;
      rd_en_reg      <= rd_en_next;
      rd_data_reg    <= rd_data_next;
      start_prev_reg <= bus.rd_start_en;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg + 13'd1;
    tmo_next     = (tmo_reg == '1) ? tmo_reg : tmo_reg + 18'd1;
    cmd_next     = cmd_reg;
    rd_en_next   = 1'b0;
    rd_data_next = rd_data_reg;
    rx_clear     = 1'b1;
    rx_shift     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SEND_CMD;
          cmd_next   = {CMD17_INDEX, bus.rd_sec_addr, CMD_CRC_DUMMY};
        end
      end
      ST_SEND_CMD: begin
        cmd_next = {cmd_reg[46:0], 1'b1};
        if (bit_cnt_reg == CMD_LAST) state_next = ST_WAIT_R1;
      end
      ST_WAIT_R1: begin
        // The first low bit on MISO is already R1 bit 7, so capture it here.
        rx_clear = 1'b0;
        if (!bus.sd_spi_miso) begin
          rx_shift   = 1'b1;
          state_next = ST_RECV_R1;
        end else if (tmo_reg == RESP_LIMIT) begin
          state_next = ST_ERR;
        end
      end
      ST_RECV_R1: begin
        rx_clear = 1'b0;
        rx_shift = 1'b1;
        if (bit_cnt_reg == 13'd6)
          state_next = (rx_word[7:0] == 8'h00) ? ST_WAIT_TOKEN : ST_ERR;
      end
      ST_WAIT_TOKEN: begin
        if (bus.sd_spi_miso == START_TOKEN[0]) state_next = ST_RECV_DATA;
        else if (tmo_reg == TOKEN_LIMIT)        state_next = ST_ERR;
      end
      ST_RECV_DATA: begin
        rx_clear = 1'b0;
        rx_shift = 1'b1;
        if (rx_done) begin
          rd_en_next   = 1'b1;
          rd_data_next = rx_word;
        end
        if (bit_cnt_reg == DATA_LAST) state_next = ST_RECV_CRC;
      end
      ST_RECV_CRC: if (bit_cnt_reg == CRC_LAST)  state_next = ST_TAIL;
      ST_TAIL:     if (bit_cnt_reg == TAIL_LAST) state_next = ST_IDLE;
      ST_ERR:      state_next = ST_TAIL;
      default:     state_next = ST_IDLE;
    endcase

    // Both counters are per-state: every transition restarts them.
    if (state_next != state_reg) begin
      bit_cnt_next = '0;
      tmo_next     = '0;
    end
  end

  assign bus.rd_busy    = (state_reg != ST_IDLE);
  assign bus.rd_sd_cs   = state_reg inside {ST_IDLE, ST_TAIL, ST_ERR};
  assign bus.rd_sd_mosi = (state_reg == ST_SEND_CMD) ? cmd_reg[47] : 1'b1;
  assign bus.rd_err     = (state_reg == ST_ERR);
  assign bus.rd_en      = rd_en_reg;
  assign bus.rd_data    = rd_data_reg;

endmodule

// File: tb/tb_sd_spi_read.sv
// Bench for sd_spi_read: a bit-queue card model answers each read; results are
// compared with values derived from the sector bytes and the wire-level timing rules.
module tb_sd_spi_read;

  localparam int RESP_T = 255;
  localparam int TOK_T  = 1000;
  localparam int TAIL   = 8;

  logic clk_sd;
  logic reset_n;

  sd_spi_read_if bus ();

  sd_spi_read #(
    .RESP_TIMEOUT  (RESP_T),
    .TOKEN_TIMEOUT (TOK_T),
    .TAIL_CLKS     (TAIL)
  ) dut (
    .clk_sd  (clk_sd),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk_sd = 1'b0;
  always #5 clk_sd = ~clk_sd;

  int          checks;
  int          failures;
  int          cyc;
  int          err_cnt;
  int          err_cyc;
  int          cs_rise_cyc;
  int          mosi_bad;
  int          cmd_bits;
  logic [47:0] cmd_got;
  logic        cs_prev;
  bit          resp_q[$];
  logic [15:0] words_q[$];
  int          en_cyc_q[$];
  logic [7:0]  byte_arr[512];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock of card model and output monitor, evaluated on the falling edge.
  task automatic step();
    @(negedge clk_sd);
    cyc++;
    if (bus.rd_sd_cs == 1'b0) begin
      if (cmd_bits < 48) begin
        cmd_got = {cmd_got[46:0], bus.rd_sd_mosi};
        cmd_bits++;
        bus.sd_spi_miso = 1'b1;
      end else begin
        if (bus.rd_sd_mosi !== 1'b1) mosi_bad++;
        if (resp_q.size() > 0) bus.sd_spi_miso = resp_q.pop_front();
        else                   bus.sd_spi_miso = 1'b1;
      end
    end else begin
      if (bus.rd_sd_mosi !== 1'b1) mosi_bad++;
      cmd_bits        = 0;
      bus.sd_spi_miso = 1'b1;
    end
    if (bus.rd_en === 1'b1) begin
      words_q.push_back(bus.rd_data);
      en_cyc_q.push_back(cyc);
    end
    if (bus.rd_err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (bus.rd_sd_cs && !cs_prev) cs_rise_cyc = cyc;
    cs_prev = bus.rd_sd_cs;
  endtask

  // r1_lat >= RESP_T: card never answers; tok_lat < 0: token never sent.
  task automatic run_read(input logic [31:0] addr, input logic [7:0] r1, input int r1_lat,
                          input int tok_lat, input bit rand_data, input int hold_at,
                          input int abort_at);
    logic [7:0]  tok;
    logic [47:0] cmd_exp;
    logic [15:0] wexp;
    bit          exp_ok, done, aborted, busy_seen;
    int          err_off, dur, busy_rise, fall_cyc, word_bad, gap_bad;

    resp_q.delete();
    words_q.delete();
    en_cyc_q.delete();
    err_cnt = 0; err_cyc = -1; cs_rise_cyc = -1; mosi_bad = 0; cmd_got = '0;
    for (int i = 0; i < 512; i++) byte_arr[i] = rand_data ? 8'($urandom) : 8'(i);

    if (r1_lat < RESP_T) begin
      repeat (r1_lat) resp_q.push_back(1'b1);
      for (int b = 7; b >= 0; b--) resp_q.push_back(r1[b]);
      if (r1 == 8'h00 && tok_lat >= 0) begin
        repeat (tok_lat) resp_q.push_back(1'b1);
        tok = 8'hFE;
        for (int b = 7; b >= 0; b--) resp_q.push_back(tok[b]);
        for (int i = 0; i < 512; i++)
          for (int b = 7; b >= 0; b--) resp_q.push_back(byte_arr[i][b]);
        repeat (16) resp_q.push_back(1'($urandom_range(0, 1)));
      end
    end

    exp_ok = (r1_lat < RESP_T) && (r1 == 8'h00) && (tok_lat >= 0);
    if (r1_lat >= RESP_T)  err_off = 48 + RESP_T;
    else if (r1 != 8'h00)  err_off = 48 + r1_lat + 8;
    else                   err_off = 48 + r1_lat + 8 + TOK_T;
    dur = exp_ok ? (48 + r1_lat + 8 + tok_lat + 8 + 4096 + 16 + TAIL) : (err_off + 1 + TAIL);

    bus.rd_sec_addr = addr;
    bus.rd_start_en = 1'b1;
    step();
    check_val("accept_busy_cs", {bus.rd_busy, bus.rd_sd_cs}, 2'b10);
    busy_rise       = cyc;
    bus.rd_start_en = 1'b0;
    bus.rd_sec_addr = $urandom;

    done = 0; aborted = 0; fall_cyc = -1;
    for (int n = 0; n < 6000 && !done && !aborted; n++) begin
      step();
      if (hold_at >= 0 && words_q.size() == hold_at) bus.rd_start_en = 1'b1;
      if (abort_at >= 0 && words_q.size() == abort_at) begin
        reset_n = 1'b0;
        #1;
        check_val("abort_outputs",
                  {bus.rd_sd_cs, bus.rd_sd_mosi, bus.rd_busy, bus.rd_en, bus.rd_data, bus.rd_err},
                  {1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0});
        repeat (4) step();
        reset_n = 1'b1;
        repeat (3) step();
        check_val("abort_words", words_q.size(), abort_at);
        check_val("abort_err", err_cnt, 0);
        aborted = 1;
      end else if (!bus.rd_busy) begin
        done     = 1;
        fall_cyc = cyc;
      end
    end
    if (aborted) return;

    check_val("finished", done, 1);
    cmd_exp = {8'h51, addr, 8'hFF};
    check_val("cmd", cmd_got, cmd_exp);
    check_val("err_pulses", err_cnt, exp_ok ? 0 : 1);
    check_val("word_count", words_q.size(), exp_ok ? 256 : 0);
    check_val("busy_len", fall_cyc - busy_rise, dur);
    check_val("mosi_idle_high", mosi_bad, 0);

    if (exp_ok) begin
      word_bad = 0;
      gap_bad  = 0;
      for (int k = 0; k < words_q.size(); k++) begin
        wexp = {byte_arr[2*k], byte_arr[2*k+1]};
        if (words_q[k] !== wexp) word_bad++;
      end
      for (int k = 1; k < en_cyc_q.size(); k++)
        if (en_cyc_q[k] - en_cyc_q[k-1] != 16) gap_bad++;
      check_val("first_word", words_q[0], {byte_arr[0], byte_arr[1]});
      check_val("word_mismatches", word_bad, 0);
      check_val("rd_en_spacing", gap_bad, 0);
      check_val("tail_after_cs", fall_cyc - cs_rise_cyc, TAIL);
      check_val("data_hold", bus.rd_data, {byte_arr[510], byte_arr[511]});
    end else begin
      check_val("err_time", err_cyc - busy_rise, err_off);
      check_val("cs_at_err", cs_rise_cyc, err_cyc);
    end

    if (hold_at >= 0) begin
      busy_seen = 0;
      repeat (20) begin
        step();
        if (bus.rd_busy) busy_seen = 1;
      end
      check_val("no_retrigger", busy_seen, 0);
      bus.rd_start_en = 1'b0;
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; cmd_bits = 0; cs_prev = 1'b1;
    err_cnt = 0; err_cyc = -1; cs_rise_cyc = -1; mosi_bad = 0; cmd_got = '0;
    bus.sd_spi_miso = 1'b1;
    bus.rd_start_en = 1'b0;
    bus.rd_sec_addr = '0;
    reset_n = 1'b0;
    repeat (3) step();
    check_val("reset_outputs",
              {bus.rd_sd_cs, bus.rd_sd_mosi, bus.rd_busy, bus.rd_en, bus.rd_data, bus.rd_err},
              {1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0});
    reset_n = 1'b1;
    repeat (3) step();

    run_read(32'h0000_1234, 8'h00, 3, 100, 1'b0, -1, -1);
    repeat (5) step();
    run_read($urandom, 8'h05, 3, 0, 1'b1, -1, -1);
    repeat (5) step();
    run_read($urandom, 8'h00, RESP_T, 0, 1'b1, -1, -1);
    repeat (5) step();
    run_read($urandom, 8'h00, 5, -1, 1'b1, -1, -1);
    repeat (5) step();
    run_read($urandom, 8'h00, $urandom_range(0, 20), $urandom_range(0, 300), 1'b1, 50, -1);
    repeat (5) step();
    run_read($urandom, 8'h00, 2, 10, 1'b1, -1, 100);
    run_read($urandom, 8'h00, $urandom_range(0, 20), $urandom_range(0, 300), 1'b1, -1, -1);
    repeat (5) step();
    run_read($urandom, 8'h00, 1, 4, 1'b1, -1, -1);
    run_read(32'hFFFF_FFFF, 8'h00, 0, 0, 1'b1, -1, -1);
    repeat (5) step();
    run_read($urandom, 8'h00, RESP_T - 1, 10, 1'b1, -1, -1);
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
